// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and the data port.
// Data has fixed priority; a starvation counter forces fetch service; hung bus cycles time out.
module mem_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_r,
    input  logic        d_w,
    input  logic [1:0]  d_sz,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [1:0]  bus_sz,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        err
);
    localparam int unsigned SW = $clog2(MAX_WAIT + 1);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          grant_fetch_q, grant_fetch_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [1:0]    bus_sz_q, bus_sz_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          err_q, err_d;
    logic          fetch_win;

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        to_cnt_d      = to_cnt_q;
        grant_fetch_d = grant_fetch_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_sz_d      = bus_sz_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_ack_d      = 1'b0;
        d_ack_d       = 1'b0;
        err_d         = 1'b0;
        fetch_win     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (if_req || d_r || d_w) begin
                    // Starved fetch beats data; otherwise data wins whenever it asks.
                    fetch_win     = (if_req && (starve_q >= SW'(MAX_WAIT))) || !(d_r || d_w);
                    grant_fetch_d = fetch_win;
                    bus_req_d     = 1'b1;
                    to_cnt_d      = '0;
                    state_d       = StBusy;
                    if (fetch_win) begin
                        bus_we_d    = 1'b0;
                        bus_sz_d    = 2'b10;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = '0;
                        starve_d    = '0;
                    end else begin
                        bus_we_d    = d_w;
                        bus_sz_d    = d_sz;
                        bus_addr_d  = d_addr;
                        bus_wdata_d = d_wdata;
                        if (if_req && (starve_q < SW'(MAX_WAIT))) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                end
            end
            StBusy: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = StDone;
                    if (grant_fetch_q) begin
                        if_rdata_d = bus_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d = bus_rdata;
                        d_ack_d   = 1'b1;
                    end
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = StDone;
                    if (grant_fetch_q) begin
                        if_rdata_d = '0;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_ack_d   = 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            StDone: begin
                state_d  = StIdle;
                to_cnt_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            starve_q      <= '0;
            to_cnt_q      <= '0;
            grant_fetch_q <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_sz_q      <= 2'b00;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            to_cnt_q      <= to_cnt_d;
            grant_fetch_q <= grant_fetch_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_sz_q      <= bus_sz_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            if_ack_q      <= if_ack_d;
            d_ack_q       <= d_ack_d;
            err_q         <= err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_sz    = bus_sz_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected bus cycles and acks are queued at issue,
// a bus responder and an ack monitor pop and compare independently.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_r, d_w;
    logic [1:0]  d_sz;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_ack;
    logic        bus_req, bus_we;
    logic [1:0]  bus_sz;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack, rsp_ack, stray_ack;
    logic        err;

    int vecs  = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        bit          hang;
        int          exp_busy;
    } bus_t;

    typedef struct {
        bit          is_fetch;
        logic [31:0] rdata;
        bit          chk_rd;
        bit          err;
        int          lat;
        int          t_issue;
    } rsp_t;

    bus_t bq[$];
    rsp_t rq[$];

    assign bus_ack = rsp_ack | stray_ack;

    mem_bus_arbiter #(.MAX_WAIT(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_r(d_r), .d_w(d_w), .d_sz(d_sz), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sz(bus_sz), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_bus(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int delay, input bit hang, input int exp_busy);
        bus_t b;
        b.we = we; b.sz = sz; b.addr = addr; b.wdata = wdata; b.rdata = rdata;
        b.delay = delay; b.hang = hang; b.exp_busy = exp_busy;
        bq.push_back(b);
    endtask

    task automatic exp_rsp(input bit is_fetch, input logic [31:0] rdata, input bit chk_rd,
                           input bit e, input int lat);
        rsp_t r;
        r.is_fetch = is_fetch; r.rdata = rdata; r.chk_rd = chk_rd; r.err = e;
        r.lat = lat; r.t_issue = cyc;
        rq.push_back(r);
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        int n = 0;
        if_req  = 1'b1;
        if_addr = addr;
        do begin @(negedge clk); n++; end while (!if_ack && n < 300);
        if (!if_ack) begin
            vecs++; fails++;
            $display("FAIL if_ack_timeout: got no ack, expected ack within 300 cycles");
        end
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic r, input logic w, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        d_r = r; d_w = w; d_sz = sz; d_addr = addr; d_wdata = wdata;
        do begin @(negedge clk); n++; end while (!d_ack && n < 300);
        if (!d_ack) begin
            vecs++; fails++;
            $display("FAIL d_ack_timeout: got no ack, expected ack within 300 cycles");
        end
        d_r = 1'b0; d_w = 1'b0;
    endtask

    // Bus responder: checks each new bus cycle against the queue and acks after its delay.
    initial begin
        bus_t cur;
        bit   in_txn = 1'b0;
        int   busy = 0;
        rsp_ack   = 1'b0;
        bus_rdata = '0;
        cur       = '{default: 0};
        forever begin
            @(negedge clk);
            rsp_ack = 1'b0;
            if (bus_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    busy   = 0;
                    if (bq.size() == 0) begin
                        vecs++; fails++;
                        $display("FAIL bus_unexpected: got bus_req addr %h, expected none",
                                 bus_addr);
                        cur = '{default: 0};
                        cur.hang = 1'b1;
                        cur.exp_busy = -1;
                    end else begin
                        cur = bq.pop_front();
                        chk("bus_we", 32'(bus_we), 32'(cur.we));
                        chk("bus_sz", 32'(bus_sz), 32'(cur.sz));
                        chk("bus_addr", bus_addr, cur.addr);
                        if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
                    end
                end
                busy++;
                if (!cur.hang && busy > cur.delay) begin
                    rsp_ack   = 1'b1;
                    bus_rdata = cur.rdata;
                end
            end else if (in_txn) begin
                in_txn = 1'b0;
                if (cur.exp_busy > 0) chk("bus_busy_cycles", busy, cur.exp_busy);
            end
        end
    end

    // Ack monitor: every ack or err must match the head of the response queue.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (if_ack || d_ack || err) begin
                if (rq.size() == 0) begin
                    vecs++; fails++;
                    $display("FAIL ack_unexpected: got if_ack=%b d_ack=%b err=%b, expected none",
                             if_ack, d_ack, err);
                end else begin
                    e = rq.pop_front();
                    chk("ack_port", {30'd0, if_ack, d_ack}, {30'd0, e.is_fetch, !e.is_fetch});
                    if (e.chk_rd) chk("rdata", e.is_fetch ? if_rdata : d_rdata, e.rdata);
                    chk("err", 32'(err), 32'(e.err));
                    if (e.lat >= 0) chk("ack_latency", cyc - e.t_issue, e.lat);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_r = 1'b0; d_w = 1'b0;
        d_sz = '0; d_addr = '0; d_wdata = '0; stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_bus_fields", {bus_we, bus_sz, bus_addr[28:0]}, 0);
        chk("rst_acks_err", {29'd0, if_ack, d_ack, err}, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        rst = 1'b1;
        @(negedge clk);

        // Fetch only, zero-wait bus: ack two cycles after the request is driven.
        exp_bus(1'b0, 2'b10, 32'h100, '0, 32'hDEADBEEF, 0, 1'b0, 1);
        exp_rsp(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 2);
        do_fetch(32'h100);

        // Byte write and fetch together: data first, then fetch.
        exp_bus(1'b1, 2'b00, 32'h2003, 32'hAB, 32'h55, 1, 1'b0, 2);
        exp_bus(1'b0, 2'b10, 32'h104, '0, 32'h12345678, 0, 1'b0, 1);
        exp_rsp(1'b0, '0, 1'b0, 1'b0, -1);
        exp_rsp(1'b1, 32'h12345678, 1'b1, 1'b0, -1);
        fork
            do_data(1'b0, 1'b1, 2'b00, 32'h2003, 32'hAB);
            do_fetch(32'h104);
        join

        // Read and write together is a write.
        exp_bus(1'b1, 2'b01, 32'h3002, 32'hBEEF, '0, 0, 1'b0, 1);
        exp_rsp(1'b0, '0, 1'b0, 1'b0, -1);
        do_data(1'b1, 1'b1, 2'b01, 32'h3002, 32'hBEEF);

        // Starvation: four data grants, then forced fetch, then remaining data.
        for (int i = 0; i < 4; i++) begin
            exp_bus(1'b0, 2'b10, 32'h4000 + 32'(4 * i), '0, 32'hA0 + 32'(i), i % 3, 1'b0,
                    (i % 3) + 1);
            exp_rsp(1'b0, 32'hA0 + 32'(i), 1'b1, 1'b0, -1);
        end
        exp_bus(1'b0, 2'b10, 32'h200, '0, 32'hF00D, 0, 1'b0, 1);
        exp_rsp(1'b1, 32'hF00D, 1'b1, 1'b0, -1);
        exp_bus(1'b0, 2'b10, 32'h4010, '0, 32'hA4, 0, 1'b0, 1);
        exp_rsp(1'b0, 32'hA4, 1'b1, 1'b0, -1);
        fork
            begin
                for (int i = 0; i < 5; i++) do_data(1'b1, 1'b0, 2'b10, 32'h4000 + 32'(4 * i), '0);
            end
            do_fetch(32'h200);
        join

        // Hung bus: abort after 64 busy cycles with err and zero data.
        exp_bus(1'b0, 2'b10, 32'h5000, '0, '0, 0, 1'b1, 64);
        exp_rsp(1'b0, '0, 1'b1, 1'b1, -1);
        do_data(1'b1, 1'b0, 2'b10, 32'h5000, '0);
        @(negedge clk);
        chk("if_rdata_hold", if_rdata, 32'hF00D);

        // Stray bus_ack while idle is ignored.
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_bus_req", 32'(bus_req), 0);
        end

        // Reset during a bus cycle drops bus_req at once and issues no ack.
        exp_bus(1'b0, 2'b10, 32'h6000, '0, '0, 0, 1'b1, -1);
        d_r = 1'b1; d_sz = 2'b10; d_addr = 32'h6000;
        repeat (4) @(negedge clk);
        chk("busy_bus_req", 32'(bus_req), 1);
        #2;
        rst = 1'b0;
        d_r = 1'b0;
        #1;
        chk("async_rst_bus_req", 32'(bus_req), 0);
        chk("async_rst_rdata", if_rdata | d_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_bus(1'b0, 2'b10, 32'h300, '0, 32'h0BADF00D, 3, 1'b0, 4);
        exp_rsp(1'b1, 32'h0BADF00D, 1'b1, 1'b0, 5);
        do_fetch(32'h300);

        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("rsp_queue_empty", rq.size(), 0);
        chk("bus_queue_empty", bq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
